// File: rtl/stream_nibble_packer_if.sv
// stream_nibble_packer_if: element input stream and packed word output bundle for stream_nibble_packer
interface stream_nibble_packer_if #(
    parameter int IN_W   = 4,
    parameter int RATIO  = 4,
    parameter int ADDR_W = 10
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CW-1:0]     out_cnt;
    logic [ADDR_W-1:0] out_addr;
    logic              out_allones;
    logic              out_allzero;
    logic              out_parity;
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_cnt, out_addr, out_allones, out_allzero, out_parity
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_cnt, out_addr, out_allones, out_allzero, out_parity
    );
endinterface

// File: rtl/stream_nibble_packer.sv
// stream_nibble_packer: packs RATIO elements MSB-first into an addressed word with reduction flags.
// Parity output is built only when STREAM_NIBBLE_PACKER_PARITY_EN is defined, else tied to 0.
module stream_nibble_packer #(
    parameter int IN_W   = 4,
    parameter int RATIO  = 4,
    parameter int ADDR_W = 10
) (
    input logic clk,
    input logic rst_n,
    stream_nibble_packer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              out_allones_q, out_allones_d;
    logic              out_allzero_q, out_allzero_d;
    logic              in_ready, accept, fire, done;
    logic [CW-1:0]     k;
    logic [OUT_W-1:0]  packed_word;

    // Stale high bits of acc are harmless: the final left shift pushes them out.
    always_comb begin
        in_ready      = state_q == HOLD ? bus.out_ready : 1'b1;
        accept        = bus.in_valid && in_ready;
        fire          = state_q == HOLD && bus.out_ready;
        k             = cnt_q + CW'(1);
        done          = accept && (k == CW'(RATIO) || bus.in_last);
        acc_d         = accept ? (acc_q << IN_W) | OUT_W'(bus.in_data) : acc_q;
        packed_word   = acc_d << (IN_W * (RATIO - int'(k)));
        cnt_d         = accept ? (done ? '0 : k) : cnt_q;
        state_d       = done ? HOLD : fire ? FILL : state_q;
        out_data_d    = done ? packed_word : out_data_q;
        out_cnt_d     = done ? k : out_cnt_q;
        out_allones_d = done ? &packed_word : out_allones_q;
        out_allzero_d = done ? ~|packed_word : out_allzero_q;
        out_addr_d    = out_addr_q + ADDR_W'(fire);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            cnt_q         <= '0;
            acc_q         <= '0;
            out_data_q    <= '0;
            out_cnt_q     <= '0;
            out_addr_q    <= '0;
            out_allones_q <= 1'b0;
            out_allzero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            out_data_q    <= out_data_d;
            out_cnt_q     <= out_cnt_d;
            out_addr_q    <= out_addr_d;
            out_allones_q <= out_allones_d;
            out_allzero_q <= out_allzero_d;
        end
    end

`ifdef STREAM_NIBBLE_PACKER_PARITY_EN
    logic out_parity_q, out_parity_d;
    assign out_parity_d = done ? ^packed_word : out_parity_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_parity_q <= 1'b0;
        else        out_parity_q <= out_parity_d;
    end
    assign bus.out_parity = out_parity_q;
`else
    assign bus.out_parity = 1'b0;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = state_q == HOLD;
    assign bus.out_data    = out_data_q;
    assign bus.out_cnt     = out_cnt_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.out_allones = out_allones_q;
    assign bus.out_allzero = out_allzero_q;
endmodule
